spi_ram_arbiter: RTL and testbench
==================================

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Parameters
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM data width; rx_data SHALL be DATA_WIDTH+2 bits.

Interface
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rx_data  in  10  SPI command word: [9:8] opcode, [7:0] payload.
REQ-006 rx_valid  in  1  rx_data valid; single-cycle pulse per word.
REQ-007 tx_data  out  8  read data returned to the SPI slave.
REQ-008 tx_valid  out  1  tx_data valid level.
REQ-009 host_req  in  1  host access request; held until host_gnt.
REQ-010 host_we  in  1  1=write, 0=read; sampled with host_req.
REQ-011 host_addr  in  8  host address.
REQ-012 host_wdata  in  8  host write data.
REQ-013 host_gnt  out  1  combinational one-cycle grant.
REQ-014 host_rvalid  out  1  host read data valid, one cycle.
REQ-015 host_rdata  out  8  host read data.
REQ-016 ram_en, ram_we  out  1 each  RAM enable and write enable.
REQ-017 ram_addr  out  8; ram_wdata  out  8  RAM address and write data.
REQ-018 ram_rdata  in  8  RAM read data, valid the cycle after the enabled read edge.
REQ-019 spi_ovf  out  1  sticky SPI command overrun flag.

Function
REQ-020 Opcode decode on rx_valid: 00 load wr_addr; 01 write payload; 10 load rd_addr; 11 read request (payload ignored).
REQ-021 Opcodes 00/10 SHALL update wr_addr/rd_addr at the capturing edge with no RAM access.
REQ-022 Opcodes 01/11 SHALL load a one-entry pending buffer {op, addr, data}; addr taken from wr_addr/rd_addr as of that edge.
REQ-023 An 01/11 word arriving while pending is full SHALL be dropped and SHALL set spi_ovf; the buffer is not overwritten.
REQ-024 Any rx_valid SHALL clear tx_valid at that edge.
REQ-025 FSM states: IDLE, SPI_RD, HOST_RD.
REQ-026 IDLE: arbitrate between pending and host_req; on grant drive ram_en=1 and ram_addr/ram_we/ram_wdata combinationally from the winner.
REQ-027 Arbitration is round-robin: on a tie the requester not granted last wins; after reset SPI wins the first tie.
REQ-028 A sole requester SHALL be granted immediately.
REQ-029 Writes SHALL complete in the grant cycle; the FSM stays in IDLE, so back-to-back writes sustain one per cycle.
REQ-030 An SPI read grant SHALL go IDLE->SPI_RD.
REQ-031 In SPI_RD, at the exiting edge, tx_data<=ram_rdata and tx_valid<=1; tx_valid then holds until the next rx_valid.
REQ-032 A host read grant SHALL go IDLE->HOST_RD.
REQ-033 In HOST_RD, host_rvalid=1 and host_rdata=ram_rdata combinationally; next state IDLE.
REQ-034 SPI_RD and HOST_RD SHALL always return to IDLE after one cycle; no grant is issued in these states.
REQ-035 The pending buffer SHALL be freed at the edge ending its grant cycle; an 01/11 word arriving at that same edge is accepted.
REQ-036 host_gnt is asserted only in the IDLE grant cycle; ram_en=0 in all other cycles.

Reset
REQ-037 On rst, at the edge: state=IDLE, pending empty, wr_addr=rd_addr=0, tx_data=0, tx_valid=0, spi_ovf=0, round-robin pointer favours SPI.
REQ-038 Reset SHALL take effect in any state, including SPI_RD/HOST_RD; an in-flight read response SHALL be discarded.
REQ-039 While rst is high: host_gnt=0, host_rvalid=0, ram_en=0.

Verification
REQ-040 SPI writes 0x005, 0x1A7 -> one cycle later ram_en=1, ram_we=1, ram_addr=0x05, ram_wdata=0xA7.
REQ-041 SPI sends 0x205 then 0x300 with RAM holding 0xA7 at 0x05 -> ram read at 0x05; two cycles after grant, tx_data=0xA7, tx_valid=1, held until the next rx_valid.
REQ-042 host_req read at 0x10 plus SPI pending write, repeated -> grants alternate SPI, host, SPI; no starvation.
REQ-043 Two 01 words arriving while pending is occupied by a stalled write -> second word dropped; spi_ovf=1 until rst; RAM sees only the first write.
REQ-044 rst asserted during SPI_RD -> tx_valid stays 0, state=IDLE next cycle, all registers at reset values.
REQ-045 Host write immediately followed by host read to the same address -> host_rdata equals the written data with host_rvalid=1 exactly one cycle.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between SPI command words and a host request port.
// SPI writes/reads go through a one-entry pending buffer; ties are resolved round-robin.
//
// state   | meaning
// IDLE    | arbitrate pending SPI access vs host_req, issue at most one RAM access
// SPI_RD  | RAM read data for the SPI returns; captured into tx_data on exit
// HOST_RD | RAM read data for the host returns on host_rdata with host_rvalid
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  spi_ovf
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SPI_RD  = 2'd1;
  localparam logic [1:0] HOST_RD = 2'd2;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_RADDR = 2'b10;

  logic [1:0]            state, state_nxt;
  logic                  pend_valid, pend_rd;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  favour_spi;
  logic                  spi_win, host_win;

  logic [1:0]            rx_op;
  logic [DATA_WIDTH-1:0] rx_payload;
  logic                  rx_access;

  assign rx_op      = rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign rx_payload = rx_data[DATA_WIDTH-1:0];
  // opcodes 01 and 11 both carry a RAM access
  assign rx_access  = rx_valid && rx_op[0];

  always_comb begin
    spi_win  = 1'b0;
    host_win = 1'b0;
    if (!rst && state == IDLE) begin
      spi_win  = pend_valid && (favour_spi || !host_req);
      host_win = host_req && !spi_win;
    end
  end

  always_comb begin
    ram_en      = spi_win || host_win;
    ram_we      = spi_win ? !pend_rd   : (host_win && host_we);
    ram_addr    = spi_win ? pend_addr  : host_addr;
    ram_wdata   = spi_win ? pend_data  : host_wdata;
    host_gnt    = host_win;
    host_rvalid = !rst && (state == HOST_RD);
    host_rdata  = ram_rdata;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (spi_win && pend_rd)        state_nxt = SPI_RD;
        else if (host_win && !host_we) state_nxt = HOST_RD;
        else                           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_rd    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      spi_ovf    <= 1'b0;
      favour_spi <= 1'b1;
    end else begin
      state <= state_nxt;

      if (spi_win || host_win) favour_spi <= host_win;

      if (rx_valid && rx_op == OP_WADDR) wr_addr <= ADDR_WIDTH'(rx_payload);
      if (rx_valid && rx_op == OP_RADDR) rd_addr <= ADDR_WIDTH'(rx_payload);

      // a buffer being granted this cycle counts as free for an arriving word
      if (rx_access && pend_valid && !spi_win) begin
        spi_ovf <= 1'b1;
      end else if (rx_access) begin
        pend_valid <= 1'b1;
        pend_rd    <= rx_op[1];
        pend_addr  <= rx_op[1] ? rd_addr : wr_addr;
        pend_data  <= rx_payload;
      end else if (spi_win) begin
        pend_valid <= 1'b0;
      end

      // a read response landing on the same edge as a new word is kept visible
      if (state == SPI_RD) begin
        tx_data  <= ram_rdata;
        tx_valid <= 1'b1;
      end else if (rx_valid) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: behavioural RAM, access/read-data scoreboard, SPI vector table
// and directed sequences for arbitration, overrun, reset and host write-then-read.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       spi_ovf;

  spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic       who;   // 1 = host
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct {
    logic [9:0] word;
    logic       acc;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       tx_chk;
    logic [7:0] tx;
  } vec_t;

  acc_t       exp_q[$];
  logic [7:0] rd_q[$];
  acc_t       mon_e;
  logic [7:0] mon_d;
  int         n_checks = 0;
  int         n_pass = 0;
  vec_t       vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic acc_t mk_acc(input logic who, input logic we, input logic [7:0] a, input logic [7:0] d);
    acc_t r;
    r.who = who; r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic vec_t mk_vec(input logic [9:0] w, input logic acc, input logic we,
                                  input logic [7:0] a, input logic [7:0] d,
                                  input logic tc, input logic [7:0] tx);
    vec_t r;
    r.word = w; r.acc = acc; r.we = we; r.addr = a; r.wdata = d; r.tx_chk = tc; r.tx = tx;
    return r;
  endfunction

  // every RAM access and every host read response is matched against the scoreboard
  always @(negedge clk) begin
    if (ram_en) begin
      if (exp_q.size() == 0) chk("ram_unexpected_access", {23'd0, ram_we, ram_addr}, 32'hffff_ffff);
      else begin
        mon_e = exp_q.pop_front();
        chk("ram_who", host_gnt, mon_e.who);
        chk("ram_we", ram_we, mon_e.we);
        chk("ram_addr", ram_addr, mon_e.addr);
        if (mon_e.we) chk("ram_wdata", ram_wdata, mon_e.wdata);
      end
    end
    if (host_rvalid) begin
      if (rd_q.size() == 0) chk("host_rvalid_unexpected", host_rdata, 32'hffff_ffff);
      else begin
        mon_d = rd_q.pop_front();
        chk("host_rdata", host_rdata, mon_d);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    if (v.acc) exp_q.push_back(mk_acc(1'b0, v.we, v.addr, v.wdata));
    send(v.word);
    @(negedge clk);
    chk("vec_ram_en", ram_en, v.acc);
    if (v.tx_chk) begin
      @(negedge clk);
      chk("vec_tx_valid_in_rd", tx_valid, 0);
      @(negedge clk);
      chk("vec_tx_valid", tx_valid, 1);
      chk("vec_tx_data", tx_data, v.tx);
    end
    tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk_vec(10'h005, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[1]  = mk_vec(10'h1A7, 1, 1, 8'h05, 8'hA7, 0, 8'h00);
    vecs[2]  = mk_vec(10'h030, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[3]  = mk_vec(10'h155, 1, 1, 8'h30, 8'h55, 0, 8'h00);
    vecs[4]  = mk_vec(10'h0FF, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[5]  = mk_vec(10'h13C, 1, 1, 8'hFF, 8'h3C, 0, 8'h00);
    vecs[6]  = mk_vec(10'h1C3, 1, 1, 8'hFF, 8'hC3, 0, 8'h00);
    vecs[7]  = mk_vec(10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[8]  = mk_vec(10'h166, 1, 1, 8'h00, 8'h66, 0, 8'h00);
    vecs[9]  = mk_vec(10'h205, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[10] = mk_vec(10'h300, 1, 0, 8'h05, 8'h00, 1, 8'hA7);
    vecs[11] = mk_vec(10'h2FF, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[12] = mk_vec(10'h3EE, 1, 0, 8'hFF, 8'h00, 1, 8'hC3);
    vecs[13] = mk_vec(10'h230, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[14] = mk_vec(10'h300, 1, 0, 8'h30, 8'h00, 1, 8'h55);

    // reset: outputs gated while rst is high, registers cleared after
    host_req = 1'b1;
    tick;
    @(negedge clk);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    tick;
    rst = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_spi_ovf", spi_ovf, 0);
    chk("reset_ram_en", ram_en, 0);
    tick;

    for (int i = 0; i < 15; i++) apply_vec(vecs[i]);

    // tx_valid holds until the next SPI word
    repeat (3) tick;
    @(negedge clk);
    chk("tx_hold_valid", tx_valid, 1);
    chk("tx_hold_data", tx_data, 8'h55);
    tick;
    send(10'h000);
    @(negedge clk);
    chk("tx_clear_on_rx", tx_valid, 0);
    tick;

    // round-robin: SPI wins first tie after reset, then grants alternate
    rst = 1'b1;
    tick;
    rst = 1'b0;
    send(10'h020);
    exp_q.push_back(mk_acc(1'b0, 1'b1, 8'h20, 8'hD1));
    exp_q.push_back(mk_acc(1'b1, 1'b0, 8'h05, 8'h00));
    exp_q.push_back(mk_acc(1'b0, 1'b1, 8'h20, 8'hD2));
    exp_q.push_back(mk_acc(1'b1, 1'b0, 8'h30, 8'h00));
    rd_q.push_back(8'hA7);
    rd_q.push_back(8'h55);
    rx_data = 10'h1D1;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("rr_idle_no_access", ram_en, 0);
    tick;
    rx_data = 10'h1D2;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    @(negedge clk);
    chk("rr_first_tie_spi", {ram_en, host_gnt}, 2'b10);
    tick;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rr_second_tie_host", host_gnt, 1);
    tick;
    host_addr = 8'h30;
    @(negedge clk);
    chk("rr_no_grant_in_host_rd", {ram_en, host_gnt}, 2'b00);
    tick;
    @(negedge clk);
    chk("rr_third_tie_spi", {ram_en, host_gnt}, 2'b10);
    tick;
    @(negedge clk);
    chk("rr_host_sole", host_gnt, 1);
    tick;
    host_req = 1'b0;
    repeat (2) tick;

    // overrun: second write word arrives while the first is stalled behind SPI_RD
    send(10'h205);
    send(10'h040);
    exp_q.push_back(mk_acc(1'b0, 1'b0, 8'h05, 8'h00));
    exp_q.push_back(mk_acc(1'b0, 1'b1, 8'h40, 8'hE1));
    send(10'h300);
    send(10'h1E1);
    send(10'h1E2);
    @(negedge clk);
    chk("ovf_set", spi_ovf, 1);
    repeat (4) tick;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    exp_q.push_back(mk_acc(1'b1, 1'b0, 8'h40, 8'h00));
    rd_q.push_back(8'hE1);
    @(negedge clk);
    chk("ovf_host_gnt", host_gnt, 1);
    tick;
    host_req = 1'b0;
    @(negedge clk);
    chk("ovf_sticky", spi_ovf, 1);
    tick;

    // reset during SPI_RD discards the read response
    exp_q.push_back(mk_acc(1'b0, 1'b0, 8'h05, 8'h00));
    send(10'h300);
    @(negedge clk);
    chk("rstrd_grant", ram_en, 1);
    tick;
    rst = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    @(negedge clk);
    chk("rstrd_gated", {ram_en, host_gnt, host_rvalid}, 3'b000);
    tick;
    rst = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    chk("rstrd_tx_valid", tx_valid, 0);
    chk("rstrd_tx_data", tx_data, 0);
    chk("rstrd_spi_ovf", spi_ovf, 0);
    chk("rstrd_ram_en", ram_en, 0);
    tick;
    apply_vec(mk_vec(10'h1AB, 1, 1, 8'h00, 8'hAB, 0, 8'h00));
    apply_vec(mk_vec(10'h300, 1, 0, 8'h00, 8'h00, 1, 8'hAB));

    // host write then host read of the same address on consecutive cycles
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h77; host_wdata = 8'h3C;
    exp_q.push_back(mk_acc(1'b1, 1'b1, 8'h77, 8'h3C));
    @(negedge clk);
    chk("hwr_gnt", host_gnt, 1);
    tick;
    host_we = 1'b0;
    exp_q.push_back(mk_acc(1'b1, 1'b0, 8'h77, 8'h00));
    rd_q.push_back(8'h3C);
    @(negedge clk);
    chk("hrd_gnt", host_gnt, 1);
    tick;
    host_req = 1'b0;
    @(negedge clk);
    chk("hrd_rvalid", host_rvalid, 1);
    tick;
    @(negedge clk);
    chk("hrd_rvalid_one_cycle", host_rvalid, 0);
    tick;

    repeat (2) tick;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
